instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Parametrised instruction memory with a hardware load engine for the pipelined processor. The block accepts a stream of machine-code words over a valid/ready port and writes them from address 0. Once the last word is written, it pads every unwritten location with the END sentinel word. It then serves a registered fetch port to the IF stage. This moves program loading out of simulation-time file I/O so one memory can be reloaded at run time.

Parameters:
WIDTH, 32, instruction word width in bits
DEPTH, 64, number of instruction words; any value >= 2, not necessarily a power of two
END_WORD, all ones (WIDTH bits), sentinel word written to unused locations and returned for invalid fetches
ADDR_W, $clog2(DEPTH), fetch address width

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  reset, asynchronous, active-high
load_start  in  1  one-cycle pulse that begins a new program load
load_valid  in  1  load_data is valid this cycle
load_data  in  WIDTH  machine-code word to store
load_last  in  1  qualifies load_data as the final word of the program
load_ready  out  1  loader accepts a word this cycle
load_count  out  ADDR_W+1  number of words accepted in the current or most recent load
overflow  out  1  sticky; DEPTH words were accepted without load_last
mem_ready  out  1  memory holds a complete program; fetch data is valid
fetch_addr  in  ADDR_W  word address from IF stage
fetch_instr  out  WIDTH  instruction read, registered

Behaviour:
- Reset values:
  - state = IDLE, wr_ptr = 0.
  - load_ready = 0, load_count = 0, overflow = 0, mem_ready = 0.
  - fetch_instr = END_WORD.
  - Memory array contents are not reset.
- The FSM has four states: IDLE, LOAD, FILL, DONE.
- IDLE:
  - load_ready = 0, mem_ready = 0.
  - load_start -> LOAD next cycle; clear wr_ptr, load_count and overflow.
- LOAD:
  - load_ready = 1. A word is accepted only when load_valid && load_ready.
  - On accept: mem[wr_ptr] <= load_data; wr_ptr++; load_count++.
  - Accept with load_last and wr_ptr < DEPTH-1 -> FILL.
  - Accept with load_last and wr_ptr == DEPTH-1 -> DONE; overflow stays 0.
  - Accept without load_last and wr_ptr == DEPTH-1 -> DONE; overflow <= 1. Any later words are refused because load_ready = 0.
  - load_valid held low simply stalls the load; there is no timeout.
- FILL:
  - load_ready = 0.
  - Each cycle: mem[wr_ptr] <= END_WORD; wr_ptr++.
  - Leave for DONE on the cycle that writes DEPTH-1.
  - Fill takes DEPTH - load_count cycles.
- DONE:
  - mem_ready = 1 from the first cycle in DONE.
  - load_start -> LOAD (same clearing as in IDLE); mem_ready drops to 0 the next cycle.
- load_start in LOAD or FILL is ignored.
- Fetch port:
  - Latency is 1 cycle: fetch_instr <= mem[fetch_addr] when mem_ready && fetch_addr < DEPTH; otherwise END_WORD.
  - The check uses mem_ready as registered in the cycle fetch_addr is presented.
  - If the fetch address equals the address being loaded/filled in the same cycle, END_WORD is returned, because mem_ready = 0 then.
- Reset mid-load or mid-fill: return immediately to reset values. Partially written memory is never visible, because mem_ready = 0.
- load_count saturates naturally at DEPTH; it needs ADDR_W+1 bits to represent DEPTH.
- There is exactly one write port (loader or filler, never both) and one read port. The memory maps to a simple dual-port RAM.

Test Plan:
- Reset, then fetch_addr = 0 -> fetch_instr = 0xFFFFFFFF, mem_ready = 0, load_ready = 0.
- load_start, then 3 words 0x20010005, 0x00221820, 0x10220002 (last on the third, valid every cycle) -> load_count = 3; FILL lasts 61 cycles; mem_ready rises; fetch 0..2 returns those words one cycle after the address; fetch 3 and fetch 63 return 0xFFFFFFFF.
- Same load with load_valid toggled every other cycle -> identical memory contents; load_ready stays 1 throughout LOAD; only the valid cycles advance load_count.
- 64 words with load_last on word 64 -> FILL is skipped, DONE on the next cycle, overflow = 0. Repeat without load_last -> overflow = 1, load_ready = 0, and a 65th valid word is not written.
- Assert rst during FILL at wr_ptr = 20 -> all outputs return to reset values at once. A new 2-word load then completes with mem_ready = 1 and addresses 2..63 equal END_WORD.
- In DONE with a program loaded, issue load_start and a new 1-word program 0x08000000 -> mem_ready = 0 during the reload, then 1 again; fetch 0 = 0x08000000, fetch 1 = 0xFFFFFFFF. With DEPTH = 48, fetch_addr = 50 returns END_WORD.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Instruction memory for the pipelined processor, with a hardware load engine.
// A program arrives as a stream of words on a valid/ready port and is written
// from address 0. When the last word is in, every location that was not
// written is padded with END_WORD. After that, the memory serves a registered
// fetch port to the IF stage. Because loading happens in hardware, the same
// memory can be reloaded at run time.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   load_start   one-cycle pulse; starts a new load (honoured in IDLE or DONE)
//   load_valid   load_data holds a word this cycle
//   load_data    machine-code word to store
//   load_last    marks load_data as the final program word
//   load_ready   loader accepts a word this cycle (high throughout LOAD)
//   load_count   words accepted in the current or most recent load
//   overflow     sticky; DEPTH words were taken without seeing load_last
//   mem_ready    memory holds a complete program, so fetch data is valid
//   fetch_addr   word address from the IF stage
//   fetch_instr  registered fetch result; END_WORD when not ready or out of range
module instr_mem_loader #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 64,
    parameter logic [WIDTH-1:0] END_WORD = '1,
    parameter int               ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [WIDTH-1:0]  fetch_instr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [ADDR_W:0]         loadCount_q, loadCount_d;
    logic                    overflow_q, overflow_d;
    logic                    memWe;
    logic [WIDTH-1:0]        memWdata;
    logic                    fetchHit;
    logic [WIDTH-1:0]        fetchInstr_q;
    logic [WIDTH-1:0]        mem [DEPTH];

    // The handshake and readiness flags come straight from the registered
    // state. As a result, a fetch can never see a partly written memory:
    // mem_ready is low in every state that writes.
    assign load_ready  = (state_q == LOAD);
    assign mem_ready   = (state_q == DONE);
    assign load_count  = loadCount_q;
    assign overflow    = overflow_q;
    assign fetch_instr = fetchInstr_q;

    // State register. It also holds the write pointer, the word count and the
    // sticky overflow flag. All of these clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            loadCount_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            loadCount_q <= loadCount_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state logic. LOAD and FILL are the only states that write, and the
    // single write port is shared between them. The state that ends on the
    // last address moves to DONE, so the pointer never needs to wrap.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        loadCount_d = loadCount_q;
        overflow_d  = overflow_q;
        memWe       = 1'b0;
        memWdata    = load_data;

        case (state_q)
            IDLE, DONE: begin
                if (load_start) begin
                    state_d     = LOAD;
                    wrPtr_d     = '0;
                    loadCount_d = '0;
                    overflow_d  = 1'b0;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    memWe       = 1'b1;
                    wrPtr_d     = wrPtr_q + 1'b1;
                    loadCount_d = loadCount_q + 1'b1;
                    if (wrPtr_q == LAST_ADDR) begin
                        // The memory is full. If load_last was not seen,
                        // the program did not fit.
                        state_d    = DONE;
                        overflow_d = !load_last;
                    end else if (load_last) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                memWe    = 1'b1;
                memWdata = END_WORD;
                wrPtr_d  = wrPtr_q + 1'b1;
                if (wrPtr_q == LAST_ADDR) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory write port. The array has no reset, so it can map onto a simple
    // dual-port RAM.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[wrPtr_q] <= memWdata;
        end
    end

    // Registered fetch. The address is range-checked because DEPTH need not
    // be a power of two. The check uses mem_ready from the cycle in which the
    // address is presented.
    assign fetchHit = mem_ready && ({1'b0, fetch_addr} < DEPTH_EXT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchInstr_q <= END_WORD;
        end else if (fetchHit) begin
            fetchInstr_q <= mem[fetch_addr];
        end else begin
            fetchInstr_q <= END_WORD;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader.
// The driver issues loads and fetches. For each one it pushes the expected
// response, taken from a program-level reference model, into a scoreboard
// tagged with the cycle in which it must appear. A monitor compares entries
// on the falling edge.
// A second instance with DEPTH = 48 shares the load stream and is used to
// check the out-of-range fetch behaviour.
module tb_instr_mem_loader;

    localparam int          DEPTH   = 64;
    localparam int          DEPTH_B = 48;
    localparam logic [31:0] END_W   = 32'hFFFF_FFFF;

    localparam int K_FETCH   = 0;
    localparam int K_FETCHB  = 1;
    localparam int K_LREADY  = 2;
    localparam int K_MREADY  = 3;
    localparam int K_LCOUNT  = 4;
    localparam int K_OVF     = 5;
    localparam int K_MREADYB = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic [5:0]  fetch_addr;
    logic [5:0]  fetchAddrB;

    logic        loadReady,  loadReadyB;
    logic [6:0]  loadCount,  loadCountB;
    logic        overflowA,  overflowB;
    logic        memReady,   memReadyB;
    logic [31:0] fetchInstr, fetchInstrB;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } sbEntry_t;

    sbEntry_t    sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cycleCount = 0;
    logic [31:0] prog[$];
    logic [31:0] refMem [DEPTH];
    bit          modelReady = 1'b0;

    instr_mem_loader #(.WIDTH(32), .DEPTH(DEPTH)) dutA (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last),
        .load_ready(loadReady), .load_count(loadCount),
        .overflow(overflowA), .mem_ready(memReady),
        .fetch_addr(fetch_addr), .fetch_instr(fetchInstr)
    );

    instr_mem_loader #(.WIDTH(32), .DEPTH(DEPTH_B)) dutB (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last),
        .load_ready(loadReadyB), .load_count(loadCountB),
        .overflow(overflowB), .mem_ready(memReadyB),
        .fetch_addr(fetchAddrB), .fetch_instr(fetchInstrB)
    );

    // Free-running clock and a cycle counter used to timestamp expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Picks the DUT output that a scoreboard entry refers to.
    function automatic logic [31:0] actualOf(input int kind);
        case (kind)
            K_FETCH:   return fetchInstr;
            K_FETCHB:  return fetchInstrB;
            K_LREADY:  return {31'b0, loadReady};
            K_MREADY:  return {31'b0, memReady};
            K_LCOUNT:  return {25'b0, loadCount};
            K_OVF:     return {31'b0, overflowA};
            K_MREADYB: return {31'b0, memReadyB};
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    // One comparison of a DUT output against its expected value.
    task automatic checkOutput(input int kind, input logic [31:0] exp, input string name);
        logic [31:0] act;
        act = actualOf(kind);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCount);
        end
    endtask

    // The monitor retires every scoreboard entry that is due this cycle. An
    // entry whose cycle has already passed counts as a failed comparison.
    always @(negedge clk) begin : monitorProc
        int idx;
        idx = 0;
        while (idx < sb.size()) begin
            if (sb[idx].due == cycleCount) begin
                checkOutput(sb[idx].kind, sb[idx].exp, sb[idx].name);
                sb.delete(idx);
            end else if (sb[idx].due < cycleCount) begin
                checks++;
                failures++;
                $display("[TB] FAIL stale_%s: got none expected check at cycle %0d", sb[idx].name, sb[idx].due);
                sb.delete(idx);
            end else begin
                idx++;
            end
        end
    end

    // A hard time limit, so the bench always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expectAt(input int due, input int kind, input logic [31:0] exp, input string name);
        sb.push_back('{due, kind, exp, name});
    endtask

    // Drives one cycle of loader inputs, then moves to 1 ns after the next
    // rising edge.
    task automatic applyStimulus(input logic start, input logic valid, input logic last,
                                 input logic [31:0] data);
        load_start = start;
        load_valid = valid;
        load_last  = last;
        load_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, $urandom);
    endtask

    // Reference model: the program words come first, and everything after
    // them is END.
    task automatic buildRef(input int n);
        for (int i = 0; i < DEPTH; i++) begin
            refMem[i] = (i < n) ? prog[i] : END_W;
        end
    endtask

    // The fetch address is captured at the next edge. Data is checked one
    // cycle later.
    task automatic fetchAt(input int addr);
        fetch_addr = 6'(addr);
        expectAt(cycleCount + 1, K_FETCH, modelReady ? refMem[addr] : END_W,
                 $sformatf("fetch%0d", addr));
        idle();
    endtask

    task automatic startLoad();
        applyStimulus(1'b1, 1'b0, 1'b0, $urandom);
        expectAt(cycleCount, K_LREADY, 32'd1, "start_ready");
        expectAt(cycleCount, K_MREADY, 32'd0, "start_memready");
        expectAt(cycleCount, K_LCOUNT, 32'd0, "start_count");
        expectAt(cycleCount, K_OVF,    32'd0, "start_ovf");
        modelReady = 1'b0;
    endtask

    // gapMode 0: valid every cycle; 1: toggle valid (with an ignored
    // load_start); 2: random stalls.
    task automatic sendWords(input int n, input bit withLast, input int gapMode);
        int gaps;
        for (int i = 0; i < n; i++) begin
            gaps = 0;
            if (gapMode == 1 && i > 0) gaps = 1;
            if (gapMode == 2) gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                expectAt(cycleCount, K_LREADY, 32'd1, "gap_ready");
                expectAt(cycleCount, K_LCOUNT, 32'(i), "gap_count");
                applyStimulus(gapMode == 1 && i == 1, 1'b0, 1'b0, $urandom);
            end
            expectAt(cycleCount, K_LREADY, 32'd1, "word_ready");
            expectAt(cycleCount, K_LCOUNT, 32'(i), "word_count");
            applyStimulus(1'b0, 1'b1, withLast && (i == n - 1), prog[i]);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Called in the cycle after the final word was accepted. It predicts the
    // fill length and the moment mem_ready rises, then waits it out.
    task automatic finishLoad(input int n, input bit withLast);
        int fillCycles;
        int lastCyc;
        lastCyc    = cycleCount;
        fillCycles = withLast ? (DEPTH - n) : 0;
        expectAt(lastCyc, K_LCOUNT, 32'(n), "done_count");
        expectAt(lastCyc, K_LREADY, 32'd0, "done_ready");
        expectAt(lastCyc, K_OVF, withLast ? 32'd0 : 32'd1, "done_ovf");
        if (fillCycles > 0) begin
            expectAt(lastCyc, K_MREADY, 32'd0, "fill_first_memready");
            expectAt(lastCyc + fillCycles - 1, K_MREADY, 32'd0, "fill_last_memready");
        end
        expectAt(lastCyc + fillCycles, K_MREADY, 32'd1, "memready_rise");
        repeat (fillCycles) idle();
        buildRef(n);
        modelReady = 1'b1;
    endtask

    task automatic randomFetches(input int count);
        for (int i = 0; i < count; i++) fetchAt($urandom_range(0, DEPTH - 1));
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        fetch_addr = '0;
        fetchAddrB = '0;
        repeat (2) @(posedge clk);
        #1;
        expectAt(cycleCount, K_FETCH,  END_W, "rst_fetch");
        expectAt(cycleCount, K_LREADY, 32'd0, "rst_ready");
        expectAt(cycleCount, K_MREADY, 32'd0, "rst_memready");
        expectAt(cycleCount, K_LCOUNT, 32'd0, "rst_count");
        idle();
        rst = 1'b0;
        fetchAt(0);
        fetchAt(5);

        $display("[TB] three-word program, valid every cycle");
        prog = '{32'h20010005, 32'h00221820, 32'h10220002};
        startLoad();
        sendWords(3, 1'b1, 0);
        finishLoad(3, 1'b1);
        fetchAt(0); fetchAt(1); fetchAt(2); fetchAt(3); fetchAt(63);
        randomFetches(6);

        $display("[TB] same program, toggled valid");
        startLoad();
        sendWords(3, 1'b1, 1);
        finishLoad(3, 1'b1);
        for (int a = 0; a < 5; a++) fetchAt(a);
        fetchAt(63);

        $display("[TB] full 64-word program with last");
        prog.delete();
        for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
        startLoad();
        sendWords(DEPTH, 1'b1, 2);
        finishLoad(DEPTH, 1'b1);
        fetchAt(0); fetchAt(63);
        randomFetches(8);

        $display("[TB] 64 words without last, then a refused 65th");
        prog.delete();
        for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
        startLoad();
        sendWords(DEPTH, 1'b0, 0);
        finishLoad(DEPTH, 1'b0);
        expectAt(cycleCount, K_LREADY, 32'd0, "ovf_refuse_ready");
        applyStimulus(1'b0, 1'b1, 1'b1, ~prog[0]);
        load_valid = 1'b0;
        load_last  = 1'b0;
        expectAt(cycleCount, K_LCOUNT, 32'd64, "ovf_count_held");
        expectAt(cycleCount, K_OVF, 32'd1, "ovf_sticky");
        fetchAt(0); fetchAt(1); fetchAt(63);
        randomFetches(4);

        $display("[TB] reset during fill");
        prog.delete();
        for (int i = 0; i < 3; i++) prog.push_back($urandom);
        startLoad();
        sendWords(3, 1'b1, 0);
        repeat (17) idle();
        rst = 1'b1;
        #1;
        modelReady = 1'b0;
        expectAt(cycleCount, K_FETCH,  END_W, "midfill_rst_fetch");
        expectAt(cycleCount, K_LREADY, 32'd0, "midfill_rst_ready");
        expectAt(cycleCount, K_MREADY, 32'd0, "midfill_rst_memready");
        expectAt(cycleCount, K_LCOUNT, 32'd0, "midfill_rst_count");
        expectAt(cycleCount, K_OVF,    32'd0, "midfill_rst_ovf");
        idle();
        rst = 1'b0;
        fetchAt(0);
        prog.delete();
        for (int i = 0; i < 2; i++) prog.push_back($urandom);
        startLoad();
        sendWords(2, 1'b1, 0);
        finishLoad(2, 1'b1);
        for (int a = 0; a < DEPTH; a++) fetchAt(a);

        $display("[TB] reload from DONE with a one-word program");
        prog = '{32'h08000000};
        startLoad();
        sendWords(1, 1'b1, 0);
        finishLoad(1, 1'b1);
        fetchAt(0); fetchAt(1);
        randomFetches(4);
        expectAt(cycleCount, K_MREADYB, 32'd1, "b_memready");
        fetchAddrB = 6'd50;
        expectAt(cycleCount + 1, K_FETCHB, END_W, "b_fetch50");
        idle();
        fetchAddrB = 6'd0;
        expectAt(cycleCount + 1, K_FETCHB, 32'h08000000, "b_fetch0");
        idle();
        fetchAddrB = 6'd1;
        expectAt(cycleCount + 1, K_FETCHB, END_W, "b_fetch1");
        idle();
        fetchAddrB = 6'd47;
        expectAt(cycleCount + 1, K_FETCHB, END_W, "b_fetch47");
        idle();
        fetchAddrB = 6'd63;
        expectAt(cycleCount + 1, K_FETCHB, END_W, "b_fetch63");
        idle();

        repeat (3) idle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
